shape_edge_sequencer: RTL and testbench

Sequences one decoded shape instruction into the ordered list of edges for a downstream line rasterizer. It accepts a packed point vector and a shape code from the instruction-processing stage over a valid/ready handshake. It then emits one (start, end) point pair per edge-side handshake: 3 edges for a triangle, 4 for a square. It sits between instruction decode and the line-drawing engine and is the only block that issues edges to that engine.

---
 rtl/shape_edge_sequencer.sv | 145 ++++++++++++++
 tb/tb_shape_edge_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_edge_sequencer.sv
// shape_edge_sequencer
// Turns one captured shape instruction (triangle or square) into its ordered
// list of closed-polygon edges, handing them one at a time to the line
// rasterizer over a valid/ready handshake.

module shape_edge_sequencer #(
    parameter int width  = 4,
    parameter int height = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            instr_valid,
    output logic                            instr_ready,
    input  logic                            shape,
    input  logic [4*(width+height)-1:0]     points,
    output logic                            edge_valid,
    input  logic                            edge_ready,
    output logic [width-1:0]                x_start,
    output logic [height-1:0]               y_start,
    output logic [width-1:0]                x_end,
    output logic [height-1:0]               y_end,
    output logic [1:0]                      edge_index,
    output logic                            last_edge,
    output logic                            busy,
    output logic                            done
);

    // One point is y in the upper bits and x in the lower bits.
    localparam int pw = width + height;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    state_t              state;
    logic                shape_q;
    logic [4*pw-1:0]     points_q;

    logic [1:0]          nxt_index;
    logic [pw-1:0]       nxt_start;
    logic [pw-1:0]       nxt_end;
    logic                nxt_last;
    logic [pw-1:0]       first_start;
    logic [pw-1:0]       first_end;

    // Extract point idx from a packed point vector.
    function automatic logic [pw-1:0] point_at(input logic [4*pw-1:0] pv,
                                               input logic [1:0]      idx);
        return pv[idx*pw +: pw];
    endfunction

    // Index of the closing edge: 2 for a triangle, 3 for a square.
    function automatic logic [1:0] last_index(input logic shp);
        return shp ? 2'd3 : 2'd2;
    endfunction

    // Point that ends edge idx; the closing edge wraps back to point 0.
    function automatic logic [1:0] end_point(input logic shp, input logic [1:0] idx);
        return (idx == last_index(shp)) ? 2'd0 : idx + 2'd1;
    endfunction

    // Only IDLE accepts work; held low while reset is asserted.
    assign instr_ready = (state == IDLE) && !reset;

    // Edge 0 comes straight from the instruction bus in the accept cycle.
    assign first_start = point_at(points, 2'd0);
    assign first_end   = point_at(points, 2'd1);

    // Precompute the edge following the current one from the captured points.
    always_comb begin
        nxt_index = edge_index + 2'd1;
        nxt_start = point_at(points_q, nxt_index);
        nxt_end   = point_at(points_q, end_point(shape_q, nxt_index));
        nxt_last  = (nxt_index == last_index(shape_q));
    end

    // Sequencer FSM: capture an instruction, walk its edges, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shape_q    <= 1'b0;
            points_q   <= '0;
            edge_valid <= 1'b0;
            x_start    <= '0;
            y_start    <= '0;
            x_end      <= '0;
            y_end      <= '0;
            edge_index <= 2'd0;
            last_edge  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    edge_valid <= 1'b0;
                    if (instr_valid) begin
                        shape_q              <= shape;
                        points_q             <= points;
                        {y_start, x_start}   <= first_start;
                        {y_end, x_end}       <= first_end;
                        edge_index           <= 2'd0;
                        last_edge            <= 1'b0;
                        edge_valid           <= 1'b1;
                        busy                 <= 1'b1;
                        state                <= EMIT;
                    end
                end

                EMIT: begin
                    if (edge_ready) begin
                        if (last_edge) begin
                            edge_valid <= 1'b0;
                            last_edge  <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            {y_start, x_start} <= nxt_start;
                            {y_end, x_end}     <= nxt_end;
                            edge_index         <= nxt_index;
                            last_edge          <= nxt_last;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    edge_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shape_edge_sequencer.sv
// tb_shape_edge_sequencer
// Directed and randomized instructions checked against a list-of-points
// model of the polygon: edge k joins point k to point (k+1) mod N.

module tb_shape_edge_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic        shape;
    logic [27:0] points;
    logic        edge_valid;
    logic        edge_ready;
    logic [3:0]  x_start;
    logic [2:0]  y_start;
    logic [3:0]  x_end;
    logic [2:0]  y_end;
    logic [1:0]  edge_index;
    logic        last_edge;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Current instruction (being checked) and the one queued behind it.
    int cx[4];
    int cy[4];
    int cs;
    int nx[4];
    int ny[4];
    int ns;

    shape_edge_sequencer #(.width(4), .height(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .shape       (shape),
        .points      (points),
        .edge_valid  (edge_valid),
        .edge_ready  (edge_ready),
        .x_start     (x_start),
        .y_start     (y_start),
        .x_end       (x_end),
        .y_end       (y_end),
        .edge_index  (edge_index),
        .last_edge   (last_edge),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the bench itself.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Build the packed bus from coordinate arrays (sel=0 current, 1 next).
    function automatic logic [27:0] pack_pts(input int sel);
        logic [27:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel == 0) v[i*7 +: 7] = {3'(cy[i]), 4'(cx[i])};
            else          v[i*7 +: 7] = {3'(ny[i]), 4'(nx[i])};
        end
        return v;
    endfunction

    task automatic randomizeNext();
        ns = int'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            nx[i] = int'($urandom_range(0, 15));
            ny[i] = int'($urandom_range(0, 7));
        end
    endtask

    task automatic promoteNext();
        cs = ns;
        for (int i = 0; i < 4; i++) begin
            cx[i] = nx[i];
            cy[i] = ny[i];
        end
    endtask

    // Expected edge k of the current polygon, checked at a negedge.
    task automatic checkEdge(input int k);
        int n;
        int e;
        n = (cs != 0) ? 4 : 3;
        e = (k + 1) % n;
        checkOutput("edge_valid", 32'(edge_valid), 1);
        checkOutput("x_start", 32'(x_start), cx[k]);
        checkOutput("y_start", 32'(y_start), cy[k]);
        checkOutput("x_end", 32'(x_end), cx[e]);
        checkOutput("y_end", 32'(y_end), cy[e]);
        checkOutput("edge_index", 32'(edge_index), k);
        checkOutput("last_edge", 32'(last_edge), (k == n - 1) ? 1 : 0);
        checkOutput("busy_emit", 32'(busy), 1);
        checkOutput("done_emit", 32'(done), 0);
        checkOutput("ready_emit", 32'(instr_ready), 0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_edge_valid", 32'(edge_valid), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_edge_index", 32'(edge_index), 0);
        checkOutput("rst_last_edge", 32'(last_edge), 0);
        checkOutput("rst_coords", {18'd0, x_start, y_start, x_end, y_end}, 0);
    endtask

    // Present the current instruction at a negedge and wait (bounded) for ready.
    task automatic applyStimulus();
        int w;
        shape       = cs[0];
        points      = pack_pts(0);
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("accept_ready", 32'(instr_ready), 1);
    endtask

    // Run one instruction. mode 0: ready always high, 1: random ready,
    // 2: three stall cycles on edge 1. overlap keeps instr_valid high with
    // the next instruction while this one is in progress.
    task automatic runInstr(input int mode, input bit overlap);
        int n;
        int k;
        int stalls;
        n = (cs != 0) ? 4 : 3;
        applyStimulus();
        edge_ready = 1'b1;
        @(negedge clk);
        if (overlap) begin
            shape  = ns[0];
            points = pack_pts(1);
        end else begin
            instr_valid = 1'b0;
            shape       = $urandom_range(0, 1) != 0;
            points      = 28'($urandom);
        end
        k = 0;
        stalls = 0;
        while (k < n) begin
            checkEdge(k);
            if (mode == 0) begin
                edge_ready = 1'b1;
            end else if (mode == 2) begin
                edge_ready = !(k == 1 && stalls < 3);
            end else begin
                edge_ready = (stalls >= 4) || ($urandom_range(0, 1) != 0);
            end
            if (edge_ready) begin
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
            @(negedge clk);
        end
        edge_ready = $urandom_range(0, 1) != 0;
        checkOutput("done_pulse", 32'(done), 1);
        checkOutput("done_busy", 32'(busy), 1);
        checkOutput("done_edge_valid", 32'(edge_valid), 0);
        checkOutput("done_ready", 32'(instr_ready), 0);
        @(negedge clk);
        checkOutput("idle_done", 32'(done), 0);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_edge_valid", 32'(edge_valid), 0);
        checkOutput("idle_ready", 32'(instr_ready), 1);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        shape       = 1'b0;
        points      = '0;
        edge_ready  = 1'b0;
        @(negedge clk);
        checkResetValues();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", 32'(instr_ready), 1);

        // Triangle (1,2) (9,2) (5,7).
        cs = 0;
        cx = '{1, 9, 5, 0};
        cy = '{2, 2, 7, 0};
        runInstr(0, 1'b0);

        // Square (0,0) (15,0) (15,7) (0,7).
        cs = 1;
        cx = '{0, 15, 15, 0};
        cy = '{0, 0, 7, 7};
        runInstr(0, 1'b0);

        // Square with a three-cycle stall on edge 1.
        randomizeNext();
        ns = 1;
        promoteNext();
        runInstr(2, 1'b0);

        // Triangle with a square queued behind it on a held instr_valid.
        randomizeNext();
        ns = 0;
        promoteNext();
        randomizeNext();
        ns = 1;
        runInstr(0, 1'b1);
        promoteNext();
        runInstr(0, 1'b0);

        // Reset while edge 2 of a square is on the outputs.
        randomizeNext();
        ns = 1;
        promoteNext();
        applyStimulus();
        edge_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkEdge(0);
        @(negedge clk);
        checkEdge(1);
        @(negedge clk);
        checkEdge(2);
        edge_ready = 1'b0;
        #1 reset = 1'b1;
        #1 checkResetValues();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_no_done", 32'(done), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_idle_ready", 32'(instr_ready), 1);
        checkOutput("rst_idle_done", 32'(done), 0);
        randomizeNext();
        promoteNext();
        runInstr(0, 1'b0);

        // Randomized instructions, random backpressure and queued sources.
        randomizeNext();
        promoteNext();
        for (int t = 0; t < 40; t++) begin
            bit ov;
            ov = $urandom_range(0, 1) != 0;
            randomizeNext();
            runInstr(1, ov);
            promoteNext();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
